// File: rtl/lane_collision_engine.sv
// Multi-lane player/obstacle collision, level-relative scoring and life/respawn sequencing.
// Optional grace period after respawn is enabled by defining COLLIDE_INVULN_EN.
module lane_collision_engine #(
  parameter int NUM_LANES      = 6,
  parameter int W              = 10,
  parameter int LANE_X0        = 80,
  parameter int LANE_PITCH     = 80,
  parameter int LANE_W         = 40,
  parameter int HALF           = 20,
  parameter int FINISH_X       = 560,
  parameter int RESPAWN_CYCLES = 2,
  parameter int LIVES          = 3,
  parameter int INVULN_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_LANES*W-1:0] bar_pos,
  input  logic [NUM_LANES*W-1:0] bar_op,
  input  logic [W-1:0]           player_h,
  input  logic [W-1:0]           player_v,
  input  logic [W-1:0]           level,
  output logic [W-1:0]           points,
  output logic                   reset_player,
  output logic [2:0]             lives,
  output logic                   level_up,
  output logic                   game_over,
  output logic [NUM_LANES-1:0]   hit_lane
);

  typedef enum logic [1:0] {S_RESPAWN, S_PLAY, S_OVER} state_t;

  localparam int             CW     = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [W:0]     HALF_X = (W+1)'(HALF);
  localparam logic [W:0]     FIN_X  = (W+1)'(FINISH_X);
  localparam logic [CW-1:0]  RESP_N = CW'(RESPAWN_CYCLES);

  function automatic logic [W-1:0] sat_points(input logic [W-1:0] lvl, input logic [3:0] prog);
    logic [2*W-1:0] full;
    full = (2*W)'(lvl) * (2*W)'(NUM_LANES) + (2*W)'(prog);
    if (|full[2*W-1:W]) return '1;
    return full[W-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             lives_q, lives_d;
  logic [W-1:0]           points_q, points_d;
  logic [NUM_LANES-1:0]   hit_lane_q, hit_lane_d;
  logic                   level_up_q, level_up_d;

  logic [NUM_LANES-1:0]   hit_c, hit_p1_q, hit_eff;
  logic [3:0]             prog_c, prog_p1_q;
  logic [W-1:0]           lvl_p1_q;
  logic                   fin_c, fin_p1_q;

  // Stage 1: per-lane box overlap and lanes-cleared count, all in W+1 bits without subtraction
  always_comb begin
    logic [W:0] ph, pv, bp, bo, lx, rx;
    hit_c  = '0;
    prog_c = '0;
    ph     = {1'b0, player_h};
    pv     = {1'b0, player_v};
    bp     = '0;
    bo     = '0;
    lx     = '0;
    rx     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lx       = (W+1)'(LANE_X0 + i * LANE_PITCH);
      rx       = lx + (W+1)'(LANE_W);
      bp       = {1'b0, bar_pos[i*W +: W]};
      bo       = {1'b0, bar_op[i*W +: W]};
      hit_c[i] = (ph + HALF_X > lx) && (ph < rx + HALF_X) &&
                 (pv + HALF_X > bp) && (pv < bp + bo + HALF_X);
      if (ph >= rx + HALF_X) prog_c = prog_c + 4'd1;
    end
    fin_c = (ph > FIN_X);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_p1_q  <= '0;
      prog_p1_q <= '0;
      lvl_p1_q  <= '0;
      fin_p1_q  <= 1'b0;
    end else begin
      // Hits seen while the player is parked are stale and must not reach the FSM
      hit_p1_q  <= (state_q == S_RESPAWN) ? '0 : hit_c;
      prog_p1_q <= prog_c;
      lvl_p1_q  <= level;
      fin_p1_q  <= fin_c;
    end
  end

`ifdef COLLIDE_INVULN_EN
  localparam int            IW    = $clog2(INVULN_CYCLES + 1);
  localparam logic [IW-1:0] INV_N = IW'(INVULN_CYCLES);
  logic [IW-1:0] inv_q, inv_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inv_q <= '0;
    else       inv_q <= inv_d;
  end

  assign hit_eff = (inv_q == '0) ? hit_p1_q : '0;
`else
  assign hit_eff = hit_p1_q;
`endif

  // Stage 2: game sequencing on the registered stage-1 results
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lives_d    = lives_q;
    points_d   = points_q;
    hit_lane_d = hit_lane_q;
    level_up_d = 1'b0;
`ifdef COLLIDE_INVULN_EN
    inv_d      = inv_q;
`endif
    case (state_q)
      S_RESPAWN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_PLAY;
          cnt_d   = '0;
`ifdef COLLIDE_INVULN_EN
          inv_d   = INV_N;
`endif
        end
      end
      S_PLAY: begin
        points_d = sat_points(lvl_p1_q, prog_p1_q);
`ifdef COLLIDE_INVULN_EN
        if (inv_q != '0) inv_d = inv_q - IW'(1);
`endif
        if (|hit_eff) begin
          hit_lane_d = hit_eff;
          points_d   = '0;
          lives_d    = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          if (lives_q <= 3'd1) begin
            state_d = S_OVER;
          end else begin
            state_d = S_RESPAWN;
            cnt_d   = RESP_N;
          end
        end else if (fin_p1_q) begin
          level_up_d = 1'b1;
          points_d   = points_q;
          state_d    = S_RESPAWN;
          cnt_d      = RESP_N;
        end
      end
      S_OVER: begin
        points_d = '0;
      end
      default: begin
        state_d = S_RESPAWN;
        cnt_d   = RESP_N;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RESPAWN;
      cnt_q      <= RESP_N;
      lives_q    <= 3'(LIVES);
      points_q   <= '0;
      hit_lane_q <= '0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lives_q    <= lives_d;
      points_q   <= points_d;
      hit_lane_q <= hit_lane_d;
      level_up_q <= level_up_d;
    end
  end

  assign points       = points_q;
  assign lives        = lives_q;
  assign hit_lane     = hit_lane_q;
  assign level_up     = level_up_q;
  assign reset_player = (state_q != S_PLAY);
  assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_lane_collision_engine.sv
// Bench for lane_collision_engine: directed scenarios then randomized play against a rule-level model.
module tb_lane_collision_engine;

  localparam int NL   = 6;
  localparam int W    = 10;
  localparam int X0   = 80;
  localparam int PIT  = 80;
  localparam int LW   = 40;
  localparam int HF   = 20;
  localparam int FINX = 500;  // finish line inside lane 5's reach so hit and finish can coincide
  localparam int RESP = 2;
  localparam int LIV  = 3;
  localparam int INV  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NL*W-1:0]     bar_pos, bar_op;
  logic [W-1:0]        player_h, player_v, level;
  logic [W-1:0]        points;
  logic                reset_player, level_up, game_over;
  logic [2:0]          lives;
  logic [NL-1:0]       hit_lane;

  lane_collision_engine #(
    .NUM_LANES(NL), .W(W), .LANE_X0(X0), .LANE_PITCH(PIT), .LANE_W(LW), .HALF(HF),
    .FINISH_X(FINX), .RESPAWN_CYCLES(RESP), .LIVES(LIV), .INVULN_CYCLES(INV)
  ) dut (
    .clk(clk), .reset(reset), .bar_pos(bar_pos), .bar_op(bar_op),
    .player_h(player_h), .player_v(player_v), .level(level),
    .points(points), .reset_player(reset_player), .lives(lives),
    .level_up(level_up), .game_over(game_over), .hit_lane(hit_lane)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: game phase, respawn countdown and a one-deep queue of sampled lane results
  typedef struct {
    int hits;
    int prog;
    int lvl;
    bit fin;
  } sample_t;

  sample_t pend[$];
  bit      m_playing, m_over;
  int      m_wait, m_lives, m_points, m_hitlane, m_inv;
  bit      m_lvlup;

  function automatic sample_t sample_inputs();
    sample_t s;
    int l, r, bp, bo;
    s.hits = 0;
    s.prog = 0;
    for (int i = 0; i < NL; i++) begin
      l  = X0 + i * PIT;
      r  = l + LW;
      bp = int'(bar_pos[i*W +: W]);
      bo = int'(bar_op[i*W +: W]);
      if (int'(player_h) + HF > l && int'(player_h) < r + HF &&
          int'(player_v) + HF > bp && int'(player_v) < bp + bo + HF)
        s.hits |= (1 << i);
      if (int'(player_h) >= r + HF) s.prog++;
    end
    s.lvl = int'(level);
    s.fin = int'(player_h) > FINX;
    return s;
  endfunction

  task automatic model_reset();
    sample_t z;
    z = '{hits: 0, prog: 0, lvl: 0, fin: 1'b0};
    pend.delete();
    pend.push_back(z);
    m_playing = 1'b0;
    m_over    = 1'b0;
    m_wait    = RESP;
    m_lives   = LIV;
    m_points  = 0;
    m_hitlane = 0;
    m_inv     = 0;
    m_lvlup   = 1'b0;
  endtask

  task automatic model_edge();
    sample_t cur, nxt;
    int eff, score;
    nxt = sample_inputs();
    if (!m_playing && !m_over) nxt.hits = 0;
    cur = pend.pop_front();
    pend.push_back(nxt);
    m_lvlup = 1'b0;
    if (m_over) begin
      m_points = 0;
    end else if (!m_playing) begin
      m_wait--;
      if (m_wait == 0) begin
        m_playing = 1'b1;
`ifdef COLLIDE_INVULN_EN
        m_inv = INV;
`endif
      end
    end else begin
      eff = (m_inv > 0) ? 0 : cur.hits;
      if (m_inv > 0) m_inv--;
      if (eff != 0) begin
        m_hitlane = eff;
        m_points  = 0;
        m_lives   = m_lives - 1;
        m_playing = 1'b0;
        if (m_lives == 0) m_over = 1'b1;
        else m_wait = RESP;
      end else if (cur.fin) begin
        m_lvlup   = 1'b1;
        m_playing = 1'b0;
        m_wait    = RESP;
      end else begin
        score    = cur.lvl * NL + cur.prog;
        m_points = (score > 1023) ? 1023 : score;
      end
    end
  endtask

  task automatic compare_all();
    chk("points", 32'(points), 32'(m_points));
    chk("reset_player", 32'(reset_player), 32'(!m_playing));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("level_up", 32'(level_up), 32'(m_lvlup));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("hit_lane", 32'(hit_lane), 32'(m_hitlane));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    #2;
    reset = 1'b0;
  endtask

  task automatic safe_inputs();
    for (int i = 0; i < NL; i++) begin
      bar_pos[i*W +: W] = W'(400);
      bar_op[i*W +: W]  = W'(10);
    end
    player_h = W'(30);
    player_v = W'(100);
  endtask

  task automatic lane_bar(input int lane, input int pos, input int len);
    bar_pos[lane*W +: W] = W'(pos);
    bar_op[lane*W +: W]  = W'(len);
  endtask

  initial begin
    reset = 1'b1;
    level = '0;
    safe_inputs();
    model_reset();
    #2;
    chk("rst_points", 32'(points), 0);
    chk("rst_reset_player", 32'(reset_player), 1);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_hit_lane", 32'(hit_lane), 0);
    chk("rst_level_up", 32'(level_up), 0);
    @(negedge clk);
    reset = 1'b0;

    step();
    chk("release_hold1", 32'(reset_player), 1);
    step();
    chk("release_play", 32'(reset_player), 0);

    // Single hit on lane 0
    level = W'(2);
    player_h = W'(100);
    player_v = W'(200);
    lane_bar(0, 190, 30);
    step();
    step();
    chk("hit_lane0", 32'(hit_lane), 32'h01);
    chk("hit_lives", 32'(lives), 2);
    chk("hit_points", 32'(points), 0);
    chk("hit_parked", 32'(reset_player), 1);
    safe_inputs();
    step();
    chk("respawn_hold", 32'(reset_player), 1);
    step();
    chk("respawn_done", 32'(reset_player), 0);

    // Progress scoring: three lanes cleared at level 1
    level = W'(1);
    player_h = W'(300);
    repeat (3) step();
    chk("progress_points", 32'(points), 9);

    // Level complete with points held
    player_h = W'(570);
    step();
    chk("finish_early", 32'(level_up), 0);
    step();
    chk("finish_pulse", 32'(level_up), 1);
    chk("finish_points", 32'(points), 9);
    player_h = W'(300);
    step();
    chk("finish_one_cycle", 32'(level_up), 0);
    repeat (3) step();

    // Hit and finish together: the hit wins
    player_h = W'(510);
    player_v = W'(100);
    lane_bar(5, 90, 20);
    step();
    step();
    chk("prio_no_level_up", 32'(level_up), 0);
    chk("prio_lives", 32'(lives), 1);
    chk("prio_hit_lane", 32'(hit_lane), 32'h20);
    safe_inputs();
    repeat (3) step();

    // Game over after three hits from a fresh start; the second uses a zero-length bar
    do_reset();
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      player_h = W'(100);
      if (k == 1) begin
        player_v = W'(185);
        lane_bar(0, 200, 0);
      end else begin
        player_v = W'(200);
        lane_bar(0, 190, 30);
      end
      step();
      step();
      safe_inputs();
      repeat (3) step();
    end
    chk("over_lives", 32'(lives), 0);
    chk("over_flag", 32'(game_over), 1);
    player_h = W'(570);
    repeat (4) step();
    chk("over_no_level_up", 32'(level_up), 0);
    chk("over_sticky", 32'(game_over), 1);
    do_reset();
    chk("reset_clears_over", 32'(game_over), 0);
    chk("reset_restores_lives", 32'(lives), 3);

    // Randomized play with occasional asynchronous resets
    safe_inputs();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      for (int i = 0; i < NL; i++) lane_bar(i, $urandom_range(0, 1023), $urandom_range(0, 60));
      player_h = W'($urandom_range(0, 700));
      player_v = W'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) level = W'($urandom_range(0, 1023));
      else if ($urandom_range(0, 9) == 0) level = W'($urandom_range(0, 5));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
